// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for MIPS DIV/DIVU.
// Produces one quotient bit per clock and presents {remainder, quotient}
// so the ALU can load HI/LO in a single assignment once ready_o rises.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;       // partial remainder
  logic [WIDTH-1:0] quot_q;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] div_q;       // divisor magnitude
  logic             neg_quot_q;  // operand signs differed on a signed request
  logic             neg_rem_q;   // dividend was negative on a signed request

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes and one restoring step, plus the sign fix-up of that step's result.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch can be inferred.
    abs_a     = opdata1_i;
    abs_b     = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) abs_a = -opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) abs_b = -opdata2_i;

    // The shifted remainder can need WIDTH+1 bits when the divisor has its MSB set,
    // so the compare is done one bit wider; the true difference always fits in WIDTH bits.
    shifted   = {rem_q, quot_q[WIDTH-1]};
    fits      = (shifted >= {1'b0, div_q});
    rem_next  = fits ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], fits};

    quot_fix  = neg_quot_q ? -quot_next : quot_next;
    rem_fix   = neg_rem_q  ? -rem_next  : rem_next;
  end

  // Control FSM and datapath registers; outputs are registered and nonzero only in DONE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      div_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      ready_o    <= 1'b0;
      result_o   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            quot_q     <= abs_a;
            div_q      <= abs_b;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_div_i && opdata1_i[WIDTH-1];
            state_q    <= (opdata2_i == '0) ? S_ZERO : S_BUSY;
          end
        end

        S_ZERO: begin
          // Division by zero is defined to return zero for both halves.
          result_o <= '0;
          ready_o  <= 1'b1;
          state_q  <= S_DONE;
        end

        S_BUSY: begin
          if (annul_i || !start_i) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_o <= {rem_fix, quot_fix};
              ready_o  <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // Hold the result until the initiator drops its request; annul is ignored here.
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end
        end

        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq with a result scoreboard.
// Stimulus pushes the hand-computed {remainder, quotient} per accepted request;
// a monitor pops and compares on every rising edge of ready_o.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op_a),
    .opdata2_i    (op_b),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare the result against the scoreboard whenever ready_o rises.
  logic prev_ready;
  initial begin
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready === 1'b1 && prev_ready !== 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
        else check("scoreboard_result", result, exp_q.pop_front());
      end
      prev_ready = ready;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Issue one request, check latency, hold in DONE, then release.
  task automatic run_div(input string name, input logic sd, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp, input int hold);
    int n;
    @(negedge clk);
    signed_div = sd; op_a = x; op_b = y; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;  // E0
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd32);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      op_a = $urandom; op_b = $urandom; signed_div = ~signed_div;
      @(posedge clk); #1;
      check({name, "_hold_ready"}, 64'(ready), 64'd1);
      check({name, "_hold_result"}, result, exp);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({name, "_release_ready"}, 64'(ready), 64'd0);
    check({name, "_release_result"}, result, 64'd0);
  endtask

  // Count ready_o highs over a window where no result may appear.
  task automatic expect_quiet(input string name, input int cycles);
    int highs;
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) highs++;
    end
    check(name, 64'(highs), 64'd0);
  endtask

  // Start 100/7 and abort at the 10th BUSY edge, either by annul or by dropping start.
  task automatic abort_run(input string name, input logic use_annul);
    @(negedge clk);
    signed_div = 1'b0; op_a = 32'd100; op_b = 32'd7; start = 1'b1; annul = 1'b0;
    @(posedge clk);            // E0
    repeat (9) @(posedge clk); // E1..E9
    @(negedge clk);
    if (use_annul) annul = 1'b1;
    else           start = 1'b0;
    @(posedge clk); #1;        // E10 aborts
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    expect_quiet({name, "_no_ready"}, 40);
    run_div({name, "_after"}, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1);
  endtask

  initial begin
    rst = 1'b1; signed_div = 1'b0; op_a = '0; op_b = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Main function and boundaries.
    run_div("u100_7",   1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 5);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 1);
    run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1);
    run_div("s_m8_m3",  1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 1);
    run_div("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 1);
    run_div("u_max_m",  1'b0, 32'hFFFFFFFF,   32'h80000000, 64'h7FFFFFFF_00000001, 1);
    run_div("s_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1);
    run_div("u5_9",     1'b0, 32'd5,          32'd9,        64'h00000005_00000000, 1);

    // Divide by zero: ready by E2, result zero, release next cycle.
    @(negedge clk);
    signed_div = 1'b0; op_a = 32'd123; op_b = 32'd0; start = 1'b1;
    exp_q.push_back(64'd0);
    @(posedge clk); #1;  // E0
    check("div0_e0_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;  // E1
    @(posedge clk); #1;  // E2
    check("div0_e2_ready", 64'(ready), 64'd1);
    check("div0_e2_result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("div0_release_ready", 64'(ready), 64'd0);

    // Aborts mid-BUSY.
    abort_run("annul", 1'b1);
    abort_run("drop_start", 1'b0);

    // start and annul together in IDLE never capture.
    @(negedge clk);
    op_a = 32'd100; op_b = 32'd7; start = 1'b1; annul = 1'b1;
    expect_quiet("start_annul_idle", 40);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;

    // Reset during BUSY clears everything, no result appears later.
    @(negedge clk);
    op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_busy_ready", 64'(ready), 64'd0);
    check("rst_busy_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    expect_quiet("rst_busy_quiet", 40);

    // Normal operation after reset.
    run_div("post_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
